// File: rtl/seven_seg_decimal.sv
// seven_seg_decimal
//   Converts a 16-bit unsigned word into five decimal digits with a
//   sequential double-dabble (shift-and-add-3) engine, one bit per clock.
//   The digits are then decoded onto five active-low seven-segment outputs.
//
// Parameters
//   BLANK_LEADING : 1 = blank digits above the most significant nonzero
//                   digit (units digit always shown); 0 = show all five.
//
// Ports
//   HCLK      in   clock, all state updates on its rising edge
//   HRESET    in   asynchronous active-high reset
//   value     in   [15:0] unsigned word to display
//   valid     in   value is meaningful; when low, the display shows dashes
//   busy      out  high while a conversion is in progress (SHIFT or LOAD)
//   HEX0..4   out  [6:0] active-low segments, bit order gfedcba;
//                  HEX0 = units, HEX4 = ten-thousands
module seven_seg_decimal #(
  parameter int BLANK_LEADING = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [15:0] value,
  input  logic        valid,
  output logic        busy,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [19:0] r_bcd;
  logic [15:0] r_sh;
  logic [15:0] r_cap;
  logic [19:0] r_disp;
  logic [15:0] r_last;
  logic        r_force;
  logic        r_valid_q;

  logic        w_start;
  logic [19:0] w_adj;
  logic [35:0] w_cat;
  logic [35:0] w_shl;
  logic [4:0]  w_keep;
  logic [6:0]  w_hex [5];

  // Add 3 to every BCD nibble that is 5 or more, so the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // A new conversion is only worth running when the word changed, or when
  // valid has dropped since the last load (force) so the result is refreshed.
  assign w_start = valid && ((value != r_last) || r_force);

  assign w_adj = add3(r_bcd);
  assign w_cat = {w_adj, r_sh};
  assign w_shl = w_cat << 1;

  assign busy = (r_state != IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = SHIFT;
      SHIFT:   if (r_cnt == 4'd15) w_next = LOAD;
      LOAD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_bcd     <= 20'd0;
      r_disp    <= 20'd0;
      r_last    <= 16'd0;
      r_force   <= 1'b1;
      r_valid_q <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_valid_q <= valid;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_bcd <= 20'd0;
            r_cnt <= 4'd0;
          end
        end
        SHIFT: begin
          r_bcd <= w_shl[35:16];
          r_cnt <= r_cnt + 4'd1;
        end
        LOAD: begin
          r_disp <= r_bcd;
          r_last <= r_cap;
        end
        default: ;
      endcase
      // A low valid always wins, so a drop during LOAD still forces a redo.
      if (!valid) r_force <= 1'b1;
      else if (r_state == LOAD) r_force <= 1'b0;
    end
  end

  // Shift register and captured word need no reset: they are only
  // consumed after a start has loaded them.
  always_ff @(posedge HCLK) begin
    if (r_state == IDLE && w_start) begin
      r_sh  <= value;
      r_cap <= value;
    end else if (r_state == SHIFT) begin
      r_sh <= w_shl[15:0];
    end
  end

  // w_keep[i] is set when digit i or any digit above it is nonzero;
  // the units digit is always kept so zero reads as "0".
  always_comb begin
    w_keep    = 5'd0;
    w_keep[4] = (r_disp[19:16] != 4'd0);
    for (int i = 3; i >= 0; i--) begin
      w_keep[i] = w_keep[i+1] | (r_disp[i*4 +: 4] != 4'd0);
    end
    w_keep[0] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_hex[i] = seg7(r_disp[i*4 +: 4]);
      if (!r_valid_q) w_hex[i] = SEG_DASH;
      else if ((BLANK_LEADING != 0) && !w_keep[i]) w_hex[i] = SEG_BLANK;
    end
  end

  assign HEX0 = w_hex[0];
  assign HEX1 = w_hex[1];
  assign HEX2 = w_hex[2];
  assign HEX3 = w_hex[3];
  assign HEX4 = w_hex[4];

endmodule

// File: tb/tb_seven_seg_decimal.sv
module tb_seven_seg_decimal;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [15:0] value = 16'd0;
  logic        valid = 1'b0;
  logic        busy, busy0;
  logic [6:0]  h0, h1, h2, h3, h4;
  logic [6:0]  z0, z1, z2, z3, z4;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [34:0] ALL_DASH = {5{7'b0111111}};

  seven_seg_decimal #(.BLANK_LEADING(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .value(value), .valid(valid), .busy(busy),
    .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4)
  );

  seven_seg_decimal #(.BLANK_LEADING(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .value(value), .valid(valid), .busy(busy0),
    .HEX0(z0), .HEX1(z1), .HEX2(z2), .HEX3(z3), .HEX4(z4)
  );

  always #5 HCLK = ~HCLK;

  wire [34:0] hex_b = {h4, h3, h2, h1, h0};
  wire [34:0] hex_z = {z4, z3, z2, z1, z0};

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {HEX4..HEX0} for a decimal number, computed with / and %.
  function automatic logic [34:0] model_hex(input int v, input bit blank, input bit vq);
    logic [34:0] r;
    int d [5];
    int p;
    int msd;
    r = '0;
    p = 1;
    msd = 0;
    for (int i = 0; i < 5; i++) begin
      d[i] = (v / p) % 10;
      if (d[i] != 0) msd = i;
      p = p * 10;
    end
    for (int i = 0; i < 5; i++) begin
      if (!vq) r[i*7 +: 7] = 7'b0111111;
      else if (blank && i > msd) r[i*7 +: 7] = 7'b1111111;
      else r[i*7 +: 7] = digit_seg(d[i]);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Drives the word, waits (bounded) for busy, then counts busy cycles.
  task automatic run_conv(input logic [15:0] v, output int busy_cycles);
    int w;
    value = v;
    valid = 1'b1;
    busy_cycles = 0;
    w = 0;
    tick();
    while (!busy && w < 40) begin
      tick();
      w++;
    end
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    valid = 1'b1;
    value = 16'd5;
    tick();
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_vec++;
    if (hex_b !== model_hex(0, 1'b1, 1'b0)) begin
      n_err++;
      $display("FAIL reset_hex: got %h want %h", hex_b, model_hex(0, 1'b1, 1'b0));
    end
    n_vec++;
    if (hex_z !== ALL_DASH) begin
      n_err++;
      $display("FAIL reset_hex_noblank: got %h want %h", hex_z, ALL_DASH);
    end
  endtask

  task automatic test_12345();
    int c;
    HRESET = 1'b0;
    run_conv(16'd12345, c);
    n_vec++;
    if (c !== 17) begin
      n_err++;
      $display("FAIL busy_len_12345: got %0d want 17", c);
    end
    n_vec++;
    if (hex_b !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}) begin
      n_err++;
      $display("FAIL hex_12345: got %h", hex_b);
    end
    n_vec++;
    if (hex_z !== model_hex(12345, 1'b0, 1'b1)) begin
      n_err++;
      $display("FAIL hex_12345_noblank: got %h want %h", hex_z, model_hex(12345, 1'b0, 1'b1));
    end
  endtask

  task automatic test_zero();
    int c;
    run_conv(16'd0, c);
    n_vec++;
    if (hex_b !== {{4{7'b1111111}}, 7'b1000000}) begin
      n_err++;
      $display("FAIL hex_zero_blank: got %h", hex_b);
    end
    n_vec++;
    if (hex_z !== {5{7'b1000000}}) begin
      n_err++;
      $display("FAIL hex_zero_noblank: got %h", hex_z);
    end
  endtask

  task automatic test_extremes();
    int c;
    run_conv(16'd65535, c);
    n_vec++;
    if (hex_b !== {7'b0000010, 7'b0010010, 7'b0010010, 7'b0110000, 7'b0010010}) begin
      n_err++;
      $display("FAIL hex_65535: got %h", hex_b);
    end
    run_conv(16'd9, c);
    n_vec++;
    if (hex_b !== {{4{7'b1111111}}, 7'b0010000}) begin
      n_err++;
      $display("FAIL hex_9: got %h", hex_b);
    end
    n_vec++;
    if (hex_z !== model_hex(9, 1'b0, 1'b1)) begin
      n_err++;
      $display("FAIL hex_9_noblank: got %h want %h", hex_z, model_hex(9, 1'b0, 1'b1));
    end
  endtask

  task automatic test_change_mid();
    int w;
    int c;
    value = 16'd100;
    valid = 1'b1;
    w = 0;
    tick();
    while (!busy && w < 40) begin
      tick();
      w++;
    end
    repeat (5) tick();
    value = 16'd7;
    c = 0;
    while (busy && c < 100) begin
      tick();
      c++;
    end
    n_vec++;
    if (hex_b !== model_hex(100, 1'b1, 1'b1)) begin
      n_err++;
      $display("FAIL hex_first_100: got %h want %h", hex_b, model_hex(100, 1'b1, 1'b1));
    end
    w = 0;
    while (!busy && w < 40) begin
      tick();
      w++;
    end
    c = 0;
    while (busy && c < 100) begin
      tick();
      c++;
    end
    n_vec++;
    if (c !== 17) begin
      n_err++;
      $display("FAIL busy_len_second: got %0d want 17", c);
    end
    n_vec++;
    if (hex_b !== {{4{7'b1111111}}, 7'b1111000}) begin
      n_err++;
      $display("FAIL hex_then_7: got %h", hex_b);
    end
  endtask

  task automatic test_valid_drop();
    int c;
    run_conv(16'd42, c);
    n_vec++;
    if (hex_b !== model_hex(42, 1'b1, 1'b1)) begin
      n_err++;
      $display("FAIL hex_42: got %h want %h", hex_b, model_hex(42, 1'b1, 1'b1));
    end
    valid = 1'b0;
    tick();
    n_vec++;
    if (hex_b !== ALL_DASH) begin
      n_err++;
      $display("FAIL dash_on_drop: got %h want %h", hex_b, ALL_DASH);
    end
    run_conv(16'd42, c);
    n_vec++;
    if (c !== 17) begin
      n_err++;
      $display("FAIL busy_len_reconvert: got %0d want 17", c);
    end
    n_vec++;
    if (hex_b !== model_hex(42, 1'b1, 1'b1)) begin
      n_err++;
      $display("FAIL hex_42_again: got %h want %h", hex_b, model_hex(42, 1'b1, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int c;
    value = 16'd999;
    valid = 1'b1;
    w = 0;
    tick();
    while (!busy && w < 40) begin
      tick();
      w++;
    end
    repeat (8) tick();
    #2;
    HRESET = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_async_reset: got %b want 0", busy);
    end
    n_vec++;
    if (hex_b !== ALL_DASH) begin
      n_err++;
      $display("FAIL dash_async_reset: got %h want %h", hex_b, ALL_DASH);
    end
    tick();
    HRESET = 1'b0;
    run_conv(16'd999, c);
    n_vec++;
    if (c !== 17) begin
      n_err++;
      $display("FAIL busy_len_999: got %0d want 17", c);
    end
    n_vec++;
    if (hex_b !== {{2{7'b1111111}}, {3{7'b0010000}}}) begin
      n_err++;
      $display("FAIL hex_999: got %h", hex_b);
    end
  endtask

  task automatic test_random();
    int c;
    int prev;
    int v;
    bit drop;
    prev = 999;
    for (int k = 0; k < 16; k++) begin
      drop = ($urandom % 4) == 0;
      v = $urandom_range(0, 65535);
      if (drop) begin
        valid = 1'b0;
        tick();
        n_vec++;
        if (hex_b !== model_hex(prev, 1'b1, 1'b0)) begin
          n_err++;
          $display("FAIL rnd_dash %0d: got %h want %h", k, hex_b, model_hex(prev, 1'b1, 1'b0));
        end
      end else begin
        while (v == prev) v = $urandom_range(0, 65535);
      end
      run_conv(v[15:0], c);
      n_vec++;
      if (c !== 17) begin
        n_err++;
        $display("FAIL rnd_busy_len %0d: got %0d want 17", k, c);
      end
      n_vec++;
      if (hex_b !== model_hex(v, 1'b1, 1'b1)) begin
        n_err++;
        $display("FAIL rnd_hex %0d val %0d: got %h want %h", k, v, hex_b, model_hex(v, 1'b1, 1'b1));
      end
      n_vec++;
      if (hex_z !== model_hex(v, 1'b0, 1'b1)) begin
        n_err++;
        $display("FAIL rnd_hex_noblank %0d val %0d: got %h want %h", k, v, hex_z, model_hex(v, 1'b0, 1'b1));
      end
      prev = v;
    end
  endtask

  initial begin
    test_reset();
    test_12345();
    test_zero();
    test_extremes();
    test_change_mid();
    test_valid_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
